// File: rtl/neighbor_count_seq.sv
// Serial Game-of-Life neighbour counter: one 3-bit adder stepped over the
// eight captured neighbour bits, then the Life rule applied to the total.

module adder3 (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    input  logic       i_c_in,
    output logic [2:0] o_sum,
    output logic       o_c_out
);

    assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {3'b000, i_c_in};

endmodule

module neighbor_count_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] neighbors,
    input  logic       alive,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    output logic       next_alive
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_nb;
    logic       r_alive;
    logic [3:0] r_acc;
    logic [2:0] r_idx;
    logic [3:0] r_count;
    logic       r_next_alive;

    logic       w_bit;
    logic [2:0] w_sum;
    logic       w_cout;
    logic       w_live;

    assign w_bit  = r_nb[r_idx];
    assign w_live = (r_acc == 4'd3) | (r_alive & (r_acc == 4'd2));

    // bit 3 is sticky: only the eighth live neighbour can carry out of the low 3 bits
    adder3 u_adder (
        .i_a     (r_acc[2:0]),
        .i_b     (3'b000),
        .i_c_in  (w_bit),
        .o_sum   (w_sum),
        .o_c_out (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        count       = r_count;
        next_alive  = r_next_alive;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (r_idx == 3'd7) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // result shown straight from the accumulator so it coincides with done
                busy        = 1'b1;
                done        = 1'b1;
                count       = r_acc;
                next_alive  = w_live;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_nb         <= '0;
            r_alive      <= 1'b0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_next_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nb    <= neighbors;
                        r_alive <= alive;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= {r_acc[3] | w_cout, w_sum};
                    r_idx <= r_idx + 3'd1;
                end
                S_DONE: begin
                    r_count      <= r_acc;
                    r_next_alive <= w_live;
                end
                default: ;
            endcase
        end
    end

endmodule
